// File: rtl/exec_trace_pkg.sv
// Shared constants, entry field layout and FSM state type for the trace player.
package exec_trace_pkg;
  localparam int DEPTH   = 64;
  localparam int DW      = 16;
  localparam int OPW     = 32;
  localparam int AW      = $clog2(DEPTH);
  localparam int NFLG    = 9;
  localparam int ENTRY_W = DW + OPW + NFLG;

  localparam int FLG_LSB = 0;
  localparam int OP_LSB  = 9;
  localparam int DLY_LSB = 9 + OPW;

  localparam int FLG_R     = 0;
  localparam int FLG_E     = 1;
  localparam int FLG_O1    = 2;
  localparam int FLG_O2    = 3;
  localparam int FLG_W1    = 4;
  localparam int FLG_W2    = 5;
  localparam int FLG_RESET = 6;
  localparam int FLG_NEXT  = 7;
  localparam int FLG_CEND  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Successor index within a trace of last+1 entries.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a, input logic [AW-1:0] last);
    logic [AW-1:0] nxt;
    if (a == last) begin
      nxt = {AW{1'b0}};
    end else begin
      nxt = a + AW'(1);
    end
    return nxt;
  endfunction
endpackage

// File: rtl/trace_ram.sv
// Trace storage: simple dual-port RAM with 1-cycle synchronous read, read-before-write.
module trace_ram
  import exec_trace_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);
  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write port and registered read port; the read sees pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/exec_trace_player.sv
// Replays stored timed steps onto exec_top's control flags and op word.
// The next entry is always prefetched so consecutive entries are gap-free.
module exec_trace_player
  import exec_trace_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               start,
  input  logic [AW:0]        length,
  input  logic               loop,
  input  logic               pause,
  output logic               r,
  output logic               e,
  output logic               o1,
  output logic               o2,
  output logic               w1,
  output logic               w2,
  output logic               reset,
  output logic               next,
  output logic               computation_end,
  output logic [OPW-1:0]     op,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      idx
);
  state_t             state, state_nx;
  logic [AW-1:0]      len_m1;
  logic               loop_q;
  logic [DW-1:0]      cnt;
  logic [AW-1:0]      pf_addr;
  logic [AW-1:0]      rd_addr;
  logic [AW-1:0]      nidx;
  logic [ENTRY_W-1:0] rd_data;
  logic [NFLG-1:0]    flags;
  logic               apply;
  logic               accept;
  logic               idle_like;
  logic               we;
  logic [AW:0]        len_clamp;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign accept    = idle_like && start && (length != {(AW+1){1'b0}});
  assign we        = idle_like && wr_en;
  assign len_clamp = (length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length;

  trace_ram u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next state, apply strobe and RAM read address (pf_addr tracks what rd_data holds).
  always_comb begin
    state_nx = state;
    apply    = 1'b0;
    nidx     = idx;
    rd_addr  = pf_addr;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nx = FETCH;
          rd_addr  = {AW{1'b0}};
        end else begin
          state_nx = state;
        end
      end
      FETCH: begin
        if (!pause) begin
          state_nx = RUN;
          apply    = 1'b1;
          nidx     = {AW{1'b0}};
          rd_addr  = wrap_inc({AW{1'b0}}, len_m1);
        end else begin
          state_nx = FETCH;
        end
      end
      RUN: begin
        if (!pause && (cnt == {DW{1'b0}})) begin
          if ((idx != len_m1) || loop_q) begin
            apply   = 1'b1;
            nidx    = wrap_inc(idx, len_m1);
            rd_addr = wrap_inc(nidx, len_m1);
          end else begin
            state_nx = DONE;
          end
        end else begin
          state_nx = RUN;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, playback parameters, delay counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      len_m1  <= {AW{1'b0}};
      loop_q  <= 1'b0;
      cnt     <= {DW{1'b0}};
      pf_addr <= {AW{1'b0}};
      flags   <= {NFLG{1'b0}};
      op      <= {OPW{1'b0}};
      idx     <= {AW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      pf_addr <= rd_addr;
      busy    <= (state_nx == FETCH) || (state_nx == RUN);
      done    <= (state_nx == DONE);
      if (accept) begin
        len_m1 <= AW'(len_clamp - (AW+1)'(1));
        loop_q <= loop;
      end
      if (apply) begin
        flags <= rd_data[FLG_LSB +: NFLG];
        op    <= rd_data[OP_LSB +: OPW];
        cnt   <= rd_data[DLY_LSB +: DW];
        idx   <= nidx;
      end else if ((state == RUN) && !pause && (cnt != {DW{1'b0}})) begin
        cnt <= cnt - DW'(1);
      end
    end
  end

  assign r               = flags[FLG_R];
  assign e               = flags[FLG_E];
  assign o1              = flags[FLG_O1];
  assign o2              = flags[FLG_O2];
  assign w1              = flags[FLG_W1];
  assign w2              = flags[FLG_W2];
  assign reset           = flags[FLG_RESET];
  assign next            = flags[FLG_NEXT];
  assign computation_end = flags[FLG_CEND];
endmodule

// File: tb/tb_exec_trace_player.sv
// Scoreboarded bench for exec_trace_player: a cycle model predicts every output cycle,
// a negedge monitor compares the DUT against the queued predictions.
module tb_exec_trace_player;
  import exec_trace_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, wr_en, start, loop, pause;
  logic [AW-1:0]      wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic [AW:0]        length;
  logic r, e, o1, o2, w1, w2, reset, next, computation_end, busy, done;
  logic [OPW-1:0]     op;
  logic [AW-1:0]      idx;
  logic [8:0]         dflg;

  assign dflg = {computation_end, next, reset, w2, w1, o2, o1, e, r};

  exec_trace_player dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .length(length), .loop(loop), .pause(pause),
    .r(r), .e(e), .o1(o1), .o2(o2), .w1(w1), .w2(w2), .reset(reset), .next(next),
    .computation_end(computation_end), .op(op), .busy(busy), .done(done), .idx(idx)
  );

  typedef struct packed {
    logic [7:0]     ph;
    logic [OPW-1:0] op;
    logic [8:0]     flg;
    logic [AW-1:0]  idx;
    logic           busy;
    logic           done;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] phase = 8'd0;

  // Reference model: trace memory plus "what is showing and for how many more cycles".
  logic [ENTRY_W-1:0] m_mem [DEPTH];
  logic [ENTRY_W-1:0] m_first;
  int   m_mode = 0;  // 0 = not playing, 1 = waiting for first entry, 2 = playing
  int   m_len = 1, m_rem = 0, m_idx = 0;
  bit   m_loop = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [OPW-1:0] m_op = '0;
  logic [8:0]     m_flg = '0;

  function automatic string ph_name(input logic [7:0] p);
    case (p)
      8'd0: return "reset";
      8'd1: return "oneshot";
      8'd2: return "pause";
      8'd3: return "busy_ignore";
      8'd4: return "loop";
      8'd5: return "midrun_reset";
      8'd6: return "len0";
      8'd7: return "rbw";
      8'd8: return "clamp";
      default: return "random";
    endcase
  endfunction

  task automatic show(input logic [ENTRY_W-1:0] ent, input int i);
    m_op  = ent[OP_LSB +: OPW];
    m_flg = ent[FLG_LSB +: 9];
    m_rem = int'(ent[DLY_LSB +: DW]) + 1;
    m_idx = i;
  endtask

  task automatic model_step();
    int nx;
    if (!rst) begin
      m_mode = 0; m_busy = 1'b0; m_done = 1'b0;
      m_op = '0; m_flg = '0; m_idx = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (start && length != 0) begin
          m_len   = (length > DEPTH) ? DEPTH : int'(length);
          m_loop  = loop;
          m_first = m_mem[0];
          m_mode  = 1; m_busy = 1'b1; m_done = 1'b0;
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
      end
      1: if (!pause) begin
        show(m_first, 0);
        m_mode = 2;
      end
      default: if (!pause) begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_idx != m_len - 1 || m_loop) begin
            nx = (m_idx + 1) % m_len;
            show(m_mem[nx], nx);
          end else begin
            m_mode = 0; m_busy = 1'b0; m_done = 1'b1;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    exp_t ex;
    @(posedge clk);
    model_step();
    ex.ph = phase; ex.op = m_op; ex.flg = m_flg; ex.idx = AW'(m_idx);
    ex.busy = m_busy; ex.done = m_done;
    exp_q.push_back(ex);
    #1;
  endtask

  // Monitor: one prediction per clock, compared away from the active edge.
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if ({op, dflg, idx, busy, done} !== {x.op, x.flg, x.idx, x.busy, x.done}) begin
        errors++;
        $display("FAIL %s t=%0t got op=%h flg=%h idx=%0d busy=%b done=%b exp op=%h flg=%h idx=%0d busy=%b done=%b",
                 ph_name(x.ph), $time, op, dflg, idx, busy, done, x.op, x.flg, x.idx, x.busy, x.done);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [ENTRY_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [AW:0] len, input logic lp);
    start = 1'b1; length = len; loop = lp;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [ENTRY_W-1:0] rand_entry();
    return {DW'($urandom_range(0, 2)), OPW'($urandom), 9'($urandom)};
  endfunction

  initial begin
    int n;
    rst = 1'b0; wr_en = 1'b0; start = 1'b0; loop = 1'b0; pause = 1'b0;
    wr_addr = '0; wr_data = '0; length = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    phase = 8'd0;
    run(3);
    rst = 1'b1;
    run(1);
    @(negedge clk);
    chk("reset_state", {32'd0, op, idx, busy, done}, 64'd0);

    phase = 8'd1;
    do_write(6'd0, {16'd0, 32'h11, 9'b000000001});
    do_write(6'd1, {16'd2, 32'h22, 9'b000000010});
    do_write(6'd2, {16'd1, 32'h33, 9'b000000100});
    do_start(7'd3, 1'b0);
    run(8);
    @(negedge clk);
    chk("oneshot_end", {op, idx, busy, done}, {24'd0, 32'h33, 6'd2, 1'b0, 1'b1});

    phase = 8'd2;
    do_start(7'd3, 1'b0);
    run(2);
    pause = 1'b1;
    run(4);
    pause = 1'b0;
    run(10);

    phase = 8'd3;
    do_start(7'd3, 1'b0);
    do_write(6'd1, {16'd5, 32'hDEAD, 9'b111111111});
    do_start(7'd1, 1'b1);
    run(10);
    do_start(7'd3, 1'b0);
    run(10);
    @(negedge clk);
    chk("replay_after_busy_write", {op, idx, done}, {25'd0, 32'h33, 6'd2, 1'b1});

    phase = 8'd4;
    do_start(7'd3, 1'b1);
    run(20);
    @(negedge clk);
    chk("loop_busy", {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});

    phase = 8'd5;
    rst = 1'b0;
    run(3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset", {23'd0, op, dflg}, 64'd0);
    run(1);

    phase = 8'd6;
    do_start(7'd0, 1'b0);
    run(2);
    @(negedge clk);
    chk("len0_idle", {62'd0, busy, done}, 64'd0);

    phase = 8'd7;
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = {16'd0, 32'h44, 9'h1FF};
    start = 1'b1; length = 7'd1; loop = 1'b0;
    tick();
    wr_en = 1'b0; start = 1'b0;
    run(3);
    @(negedge clk);
    chk("rbw_old_data", {op, done}, {31'd0, 32'h11, 1'b1});
    do_start(7'd1, 1'b0);
    run(3);
    @(negedge clk);
    chk("rbw_new_data", {op, done}, {31'd0, 32'h44, 1'b1});

    phase = 8'd8;
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), rand_entry());
    do_start(7'd65, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) begin
      errors++;
      checks++;
      $display("FAIL clamp_timeout got done=%b after %0d cycles want done=1", done, n);
    end
    @(negedge clk);
    chk("clamp_end", {idx, done}, {57'd0, 6'd63, 1'b1});

    phase = 8'd9;
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) != 0);
      wr_en   = rst && ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom);
      wr_data = rand_entry();
      start   = ($urandom_range(0, 19) == 0);
      length  = (AW+1)'($urandom_range(0, 70));
      loop    = ($urandom_range(0, 3) == 0);
      pause   = ($urandom_range(0, 4) == 0);
      tick();
    end
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; pause = 1'b0;

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
